// File: rtl/button_ctrl_pkg.sv
// button_ctrl_pkg
// Shared definitions for the push-button controller: Avalon word addresses
// of the visible registers and the debounce counter width helper.
// No ports (package).
package button_ctrl_pkg;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd1;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  // Counter only ever has to hold 0 .. debounce_cycles-1.
  // The result is at least 1 bit so degenerate settings still elaborate.
  function automatic int cnt_width(input int debounce_cycles);
    int w;
    w = $clog2(debounce_cycles);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// button_debounce
// Single-bit synchroniser + debouncer for one active-low button line.
// Ports:
//   clk    - system clock
//   reset  - synchronous active-high reset (line treated as released)
//   din    - raw asynchronous button line
//   dout   - debounced level (1 = released)
//   fall   - high in the cycle whose clock edge will take dout 1->0
module button_debounce
  import button_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout,
  output logic fall
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          s_meta;
  logic          s;
  logic [CW-1:0] cnt;
  logic          accept;

  // The new level is accepted on the edge where the counter has already
  // seen DEBOUNCE_CYCLES-1 differing samples and the current one differs too.
  assign accept = (s != dout) && (cnt == CNT_LAST);

  // Exposed combinationally so the parent can capture the press on the very
  // edge that dout falls.
  assign fall = accept && dout;

  always_ff @(posedge clk) begin
    if (reset) begin
      s_meta <= 1'b1;
      s      <= 1'b1;
      dout   <= 1'b1;
      cnt    <= '0;
    end else begin
      s_meta <= din;
      s      <= s_meta;
      if (s == dout) begin
        cnt <= '0;
      end else if (accept) begin
        dout <= s;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/nios_button_ctrl.sv
// nios_button_ctrl
// Avalon-MM slave for the board push-buttons: debounced level, interrupt
// mask, write-1-to-clear press capture and a level interrupt.
// Ports:
//   clk, reset            - system clock, synchronous active-high reset
//   in_port[WIDTH]        - raw active-low button lines (asynchronous)
//   address[2]            - word address (0 DATA, 1 MASK, 2 reserved, 3 EDGE)
//   read, write           - Avalon strobes
//   writedata[32]         - write data (bits >= WIDTH ignored)
//   readdata[32]          - registered read data, 1-cycle latency
//   irq                   - registered level interrupt
module nios_button_ctrl
  import button_ctrl_pkg::*;
#(
  parameter int WIDTH           = 3,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_port,
  input  logic [1:0]       address,
  input  logic             read,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] db;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_cap;
  logic [WIDTH-1:0] edge_clr;
  logic [31:0]      rd_next;
  logic             unused_wdata;

  assign unused_wdata = ^writedata[31:WIDTH];

  for (genvar i = 0; i < WIDTH; i++) begin : g_db
    button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk  (clk),
      .reset(reset),
      .din  (in_port[i]),
      .dout (db[i]),
      .fall (fall[i])
    );
  end

  assign edge_clr = (write && (address == ADDR_EDGE)) ? writedata[WIDTH-1:0] : '0;

  always_comb begin
    rd_next = '0;
    case (address)
      ADDR_DATA: rd_next[WIDTH-1:0] = db;
      ADDR_MASK: rd_next[WIDTH-1:0] = irq_mask;
      ADDR_EDGE: rd_next[WIDTH-1:0] = edge_cap;
      default:   rd_next = '0;
    endcase
  end

  // OR-ing the new press in after the clear makes a colliding set win.
  // irq looks at the already-registered edge_cap/irq_mask, so it trails
  // any change to them by one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_mask <= '0;
      edge_cap <= '0;
      readdata <= '0;
      irq      <= 1'b0;
    end else begin
      if (write && (address == ADDR_MASK)) begin
        irq_mask <= writedata[WIDTH-1:0];
      end
      edge_cap <= (edge_cap & ~edge_clr) | fall;
      irq      <= |(edge_cap & irq_mask);
      if (read) begin
        readdata <= rd_next;
      end
    end
  end

endmodule

// File: tb/tb_nios_button_ctrl.sv
// tb_nios_button_ctrl
// Directed scenarios plus randomized traffic for nios_button_ctrl with
// WIDTH=3, DEBOUNCE_CYCLES=4. A behavioural model tracks the expected
// register contents, readdata and irq.
// No ports (testbench top).
module tb_nios_button_ctrl;

  localparam int W     = 3;
  localparam int DC    = 4;
  localparam int DEPTH = DC + 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [W-1:0]  in_port;
  logic [1:0]    address;
  logic          read;
  logic          write;
  logic [31:0]   writedata;
  logic [31:0]   readdata;
  logic          irq;

  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;

  // Model state: raw input samples (newest first) and register contents.
  logic [W-1:0] raw [DEPTH];
  logic [W-1:0] m_db;
  logic [W-1:0] m_mask;
  logic [W-1:0] m_edge;
  logic [31:0]  m_rd;
  logic         m_irq;

  always #5 clk = ~clk;

  nios_button_ctrl #(
    .WIDTH(W),
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_port  (in_port),
    .address  (address),
    .read     (read),
    .write    (write),
    .writedata(writedata),
    .readdata (readdata),
    .irq      (irq)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a line is accepted once the last DC synchronised
  // samples (raw input delayed by two edges) all disagree with the held level.
  initial begin
    logic [W-1:0] old_db, old_edge, old_mask, clr, flip;
    forever begin
      @(posedge clk);
      if (reset) begin
        for (int k = 0; k < DEPTH; k++) raw[k] = '1;
        m_db   = '1;
        m_mask = '0;
        m_edge = '0;
        m_rd   = '0;
        m_irq  = 1'b0;
      end else begin
        old_db   = m_db;
        old_edge = m_edge;
        old_mask = m_mask;
        for (int k = DEPTH - 1; k > 0; k--) raw[k] = raw[k-1];
        raw[0] = in_port;
        for (int i = 0; i < W; i++) begin
          flip[i] = 1'b1;
          for (int k = 2; k < DEPTH; k++)
            if (raw[k][i] == old_db[i]) flip[i] = 1'b0;
        end
        m_db = old_db ^ flip;
        clr  = (write && address == 2'd3) ? writedata[W-1:0] : '0;
        if (write && address == 2'd1) m_mask = writedata[W-1:0];
        m_edge = (old_edge & ~clr) | (old_db & ~m_db);
        m_irq  = |(old_edge & old_mask);
        if (read) begin
          case (address)
            2'd0:    m_rd = {29'b0, old_db};
            2'd1:    m_rd = {29'b0, old_mask};
            2'd3:    m_rd = {29'b0, old_edge};
            default: m_rd = 32'h0;
          endcase
        end
      end
    end
  end

  // Every cycle: DUT outputs against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        checkOutput("readdata", readdata, m_rd);
        checkOutput("irq", {31'b0, irq}, {31'b0, m_irq});
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic readReg(input logic [1:0] addr, output logic [31:0] val);
    address = addr;
    read    = 1'b1;
    @(negedge clk);
    val = readdata;
    #1;
    read = 1'b0;
  endtask

  task automatic writeReg(input logic [1:0] addr, input logic [31:0] data);
    address   = addr;
    writedata = data;
    write     = 1'b1;
    @(negedge clk);
    #1;
    write = 1'b0;
  endtask

  task automatic applyStimulus(input logic rst, input logic [W-1:0] port, input logic [1:0] addr,
                               input logic rd, input logic wr, input logic [31:0] wdata);
    reset     = rst;
    in_port   = port;
    address   = addr;
    read      = rd;
    write     = wr;
    writedata = wdata;
    @(negedge clk);
    #1;
    reset = 1'b0;
    read  = 1'b0;
    write = 1'b0;
  endtask

  initial begin
    logic [31:0] v;
    logic [W-1:0] tog;
    int op;
    reset     = 1'b1;
    in_port   = '1;
    address   = 2'd0;
    read      = 1'b0;
    write     = 1'b0;
    writedata = 32'h0;
    idle(2);
    reset  = 1'b0;
    cmp_en = 1'b1;

    // Reset state
    readReg(2'd0, v); checkOutput("reset_data", v, 32'h7);
    readReg(2'd1, v); checkOutput("reset_mask", v, 32'h0);
    readReg(2'd3, v); checkOutput("reset_edge", v, 32'h0);
    checkOutput("reset_irq", {31'b0, irq}, 32'h0);

    // Bounce on line 1 never settles long enough
    in_port = 3'b101;
    for (int n = 0; n < 10; n++) begin
      idle(2);
      in_port[1] = ~in_port[1];
    end
    in_port = 3'b111;
    idle(8);
    readReg(2'd0, v); checkOutput("bounce_data", v, 32'h7);
    readReg(2'd3, v); checkOutput("bounce_edge", v, 32'h0);

    // Clean press on line 0 with mask enabled
    writeReg(2'd1, 32'hFFFF_FFF9);
    readReg(2'd1, v); checkOutput("mask_rd", v, 32'h1);
    in_port = 3'b110;
    idle(6);
    checkOutput("press_irq_lag", {31'b0, irq}, 32'h0);
    idle(1);
    checkOutput("press_irq", {31'b0, irq}, 32'h1);
    readReg(2'd0, v); checkOutput("press_data", v, 32'h6);
    readReg(2'd3, v); checkOutput("press_edge", v, 32'h1);

    // W1C
    writeReg(2'd1, 32'h5);
    in_port = 3'b010;
    idle(8);
    readReg(2'd3, v); checkOutput("w1c_start", v, 32'h5);
    writeReg(2'd0, 32'h0);
    writeReg(2'd2, 32'h7);
    readReg(2'd0, v); checkOutput("ro_data", v, 32'h2);
    readReg(2'd2, v); checkOutput("rsvd", v, 32'h0);
    writeReg(2'd3, 32'h1);
    readReg(2'd3, v); checkOutput("w1c_bit0", v, 32'h4);
    writeReg(2'd3, 32'h4);
    checkOutput("w1c_irq_hold", {31'b0, irq}, 32'h1);
    idle(1);
    checkOutput("w1c_irq_fall", {31'b0, irq}, 32'h0);
    readReg(2'd3, v); checkOutput("w1c_bit2", v, 32'h0);

    // Set/clear collision on line 2
    in_port = 3'b111;
    idle(10);
    writeReg(2'd3, 32'h7);
    readReg(2'd3, v); checkOutput("coll_pre", v, 32'h0);
    in_port = 3'b011;
    idle(5);
    writeReg(2'd3, 32'h4);
    readReg(2'd3, v); checkOutput("coll_edge", v, 32'h4);

    // Reset mid-count on line 0
    in_port = 3'b111;
    idle(10);
    writeReg(2'd3, 32'h7);
    in_port = 3'b110;
    idle(4);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    readReg(2'd0, v); checkOutput("rst_mid_data", v, 32'h7);
    readReg(2'd3, v); checkOutput("rst_mid_edge", v, 32'h0);
    idle(2);
    readReg(2'd0, v); checkOutput("rst_mid_early", v, 32'h7);
    idle(1);
    readReg(2'd0, v); checkOutput("rst_mid_accept", v, 32'h6);

    // Randomized traffic, model-checked every cycle
    for (int n = 0; n < 3000; n++) begin
      tog = '0;
      for (int i = 0; i < W; i++) tog[i] = ($urandom_range(0, 7) == 0);
      op = $urandom_range(0, 3);
      applyStimulus(($urandom_range(0, 399) == 0), in_port ^ tog, 2'($urandom_range(0, 3)),
                    (op == 1 || op == 3), (op == 2 || op == 3), $urandom);
    end

    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
